dfi_init_seq: RTL and testbench



---
 rtl/dfi_init_seq.sv | 162 ++++++++++++++++
 tb/tb_dfi_init_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dfi_init_seq.sv
// dfi_init_seq: DFI power-up sequencer (reset hold, CKE wait, MRW list, ZQ calibration when DFI_INIT_ZQCAL_EN is defined)
module dfi_init_seq #(
    parameter int T_RESET_CYC = 200,
    parameter int T_CKE_CYC   = 500,
    parameter int T_MRD_CYC   = 10,
    parameter int T_ZQ_CYC    = 512,
    parameter int N_MRW       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic [N_MRW*23-1:0]  mrw_table_i,
    output logic                 dfi_reset_n_o,
    output logic                 dfi_cke_o,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic [16:0]          cmd_address_o,
    output logic [5:0]           cmd_bank_o,
    output logic                 cmd_cs_n_o,
    output logic                 cmd_ras_n_o,
    output logic                 cmd_cas_n_o,
    output logic                 cmd_we_n_o
);
    localparam int T_MAX_A = T_RESET_CYC > T_CKE_CYC ? T_RESET_CYC : T_CKE_CYC;
    localparam int T_MAX_B = T_MAX_A > T_MRD_CYC ? T_MAX_A : T_MRD_CYC;
`ifdef DFI_INIT_ZQCAL_EN
    localparam int T_MAX = T_MAX_B > T_ZQ_CYC ? T_MAX_B : T_ZQ_CYC;
`else
    localparam int T_MAX = T_MAX_B;
`endif
    localparam int CW = $clog2(T_MAX + 1);
    localparam int IW = N_MRW > 1 ? $clog2(N_MRW) : 1;

    if (T_RESET_CYC < 1 || T_CKE_CYC < 1 || T_MRD_CYC < 1 || T_ZQ_CYC < 1 || N_MRW < 1) begin : g_param_err
        $error("dfi_init_seq: timing parameters and N_MRW must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE, RST_HOLD, CKE_WAIT, MRW_CMD, MRW_WAIT, ZQ_CMD, ZQ_WAIT, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d, done_q, done_d, rst_n_q, rst_n_d, cke_q, cke_d;
    logic            valid_q, valid_d, cs_n_q, cs_n_d, ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
    logic [16:0]     addr_q, addr_d;
    logic [5:0]      bank_q, bank_d;
    logic [22:0]     mrw_tab [N_MRW];

    for (genvar k = 0; k < N_MRW; k++) begin : g_tab
        assign mrw_tab[k] = mrw_table_i[23*k +: 23];
    end

    // Next state, wait/idx counters, and next values of every registered output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = RST_HOLD;
                cnt_d   = CW'(T_RESET_CYC - 1);
            end
            RST_HOLD: if (cnt_q == '0) begin
                state_d = CKE_WAIT;
                cnt_d   = CW'(T_CKE_CYC - 1);
            end else cnt_d = cnt_q - CW'(1);
            CKE_WAIT: if (cnt_q == '0) begin
                state_d = MRW_CMD;
                idx_d   = '0;
            end else cnt_d = cnt_q - CW'(1);
            MRW_CMD: if (cmd_ready_i) begin
                state_d = MRW_WAIT;
                cnt_d   = CW'(T_MRD_CYC - 1);
            end
            MRW_WAIT: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else if (idx_q == IW'(N_MRW - 1)) begin
`ifdef DFI_INIT_ZQCAL_EN
                state_d = ZQ_CMD;
`else
                state_d = DONE;
`endif
            end else begin
                state_d = MRW_CMD;
                idx_d   = idx_q + IW'(1);
            end
`ifdef DFI_INIT_ZQCAL_EN
            ZQ_CMD: if (cmd_ready_i) begin
                state_d = ZQ_WAIT;
                cnt_d   = CW'(T_ZQ_CYC - 1);
            end
            ZQ_WAIT: if (cnt_q == '0) state_d = DONE;
            else cnt_d = cnt_q - CW'(1);
`endif
            DONE: if (!start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = state_d != IDLE && state_d != DONE;
        done_d  = state_d == DONE;
        rst_n_d = state_d == IDLE ? rst_n_q : state_d != RST_HOLD;
        cke_d   = state_d == IDLE ? cke_q : state_d != RST_HOLD && state_d != CKE_WAIT;
        valid_d = state_d == MRW_CMD || state_d == ZQ_CMD;
        cs_n_d  = !valid_d;
        ras_n_d = state_d != MRW_CMD;
        cas_n_d = state_d != MRW_CMD;
        we_n_d  = !valid_d;
        addr_d  = (state_d == MRW_CMD && state_q != MRW_CMD) ? mrw_tab[idx_d][16:0] :
                  state_d == ZQ_CMD ? 17'h00400 : addr_q;
        bank_d  = (state_d == MRW_CMD && state_q != MRW_CMD) ? mrw_tab[idx_d][22:17] :
                  state_d == ZQ_CMD ? 6'd0 : bank_q;
    end

    // State, counters and registered outputs with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rst_n_q <= 1'b0;
            cke_q   <= 1'b0;
            valid_q <= 1'b0;
            cs_n_q  <= 1'b1;
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
            addr_q  <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rst_n_q <= rst_n_d;
            cke_q   <= cke_d;
            valid_q <= valid_d;
            cs_n_q  <= cs_n_d;
            ras_n_q <= ras_n_d;
            cas_n_q <= cas_n_d;
            we_n_q  <= we_n_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign dfi_reset_n_o = rst_n_q;
    assign dfi_cke_o     = cke_q;
    assign cmd_valid_o   = valid_q;
    assign cmd_cs_n_o    = cs_n_q;
    assign cmd_ras_n_o   = ras_n_q;
    assign cmd_cas_n_o   = cas_n_q;
    assign cmd_we_n_o    = we_n_q;
    assign cmd_address_o = addr_q;
    assign cmd_bank_o    = bank_q;
endmodule

// File: tb/tb_dfi_init_seq.sv
// tb_dfi_init_seq: directed cycle-accurate checks of the DFI init sequencer
module tb_dfi_init_seq;
`ifdef DFI_INIT_ZQCAL_EN
    localparam bit ZQ = 1'b1;
`else
    localparam bit ZQ = 1'b0;
`endif
    localparam logic [45:0] TAB = {6'h02, 17'h1ABCD, 6'h01, 17'h00123};

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [45:0] tab;
    logic        busy, done, rst_n, cke, valid, cs_n, ras_n, cas_n, we_n;
    logic [16:0] addr;
    logic [5:0]  bank;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    dfi_init_seq #(
        .T_RESET_CYC(4), .T_CKE_CYC(6), .T_MRD_CYC(2), .T_ZQ_CYC(8), .N_MRW(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .mrw_table_i(tab), .dfi_reset_n_o(rst_n), .dfi_cke_o(cke),
        .cmd_valid_o(valid), .cmd_ready_i(ready), .cmd_address_o(addr), .cmd_bank_o(bank),
        .cmd_cs_n_o(cs_n), .cmd_ras_n_o(ras_n), .cmd_cas_n_o(cas_n), .cmd_we_n_o(we_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s@%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_out(input logic e_rn, input logic e_cke, input logic e_busy, input logic e_done,
                              input logic e_valid, input logic [3:0] e_cmd, input logic [16:0] e_addr,
                              input logic [5:0] e_bank, input bit chk_ab);
        chk("reset_n", 32'(rst_n), 32'(e_rn));
        chk("cke", 32'(cke), 32'(e_cke));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("valid", 32'(valid), 32'(e_valid));
        chk("cs_ras_cas_we", 32'({cs_n, ras_n, cas_n, we_n}), 32'(e_cmd));
        if (chk_ab) begin
            chk("address", 32'(addr), 32'(e_addr));
            chk("bank", 32'(bank), 32'(e_bank));
        end
    endtask

    // One full sequence starting in cycle 1 (start sampled at the preceding edge); s = ready stall cycles in MRW0
    task automatic run(input int s, input bit held, input int last);
        int  d;
        bit  m0, m1, z;
        d = (ZQ ? 26 : 17) + s;
        for (int c = 1; c <= last; c++) begin
            cyc = c;
            ready = !(c >= 11 && c < 11 + s);
            if (!held && c == 3) start = 1'b0;
            if (s > 0 && c == 12) tab = '1;
            if (s > 0 && c == 17) tab = TAB;
            m0 = c >= 11 && c <= 11 + s;
            m1 = c == 14 + s;
            z  = ZQ && c == 17 + s;
            expect_out(c >= 5, c >= 11, c < d, held ? c >= d : c == d, m0 || m1 || z,
                       (m0 || m1) ? 4'b0000 : z ? 4'b0110 : 4'b1111,
                       m0 ? 17'h00123 : m1 ? 17'h1ABCD : 17'h00400,
                       m0 ? 6'h01 : m1 ? 6'h02 : 6'h00, m0 || m1 || z);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b1; tab = TAB;
        tick(); tick();
        cyc = 0;
        expect_out(0, 0, 0, 0, 0, 4'hF, 17'h0, 6'h0, 1);
        rst = 1'b0;
        tick();
        expect_out(0, 0, 0, 0, 0, 4'hF, 17'h0, 6'h0, 1);
        start = 1'b1;
        tick();
        run(0, 1, (ZQ ? 26 : 17) + 2);
        start = 1'b0;
        tick();
        expect_out(1, 1, 0, 0, 0, 4'hF, 17'h0, 6'h0, 0);
        start = 1'b1;
        tick();
        run(5, 1, (ZQ ? 26 : 17) + 6);
        start = 1'b0;
        tick();
        expect_out(1, 1, 0, 0, 0, 4'hF, 17'h0, 6'h0, 0);
        start = 1'b1;
        tick();
        run(0, 0, (ZQ ? 26 : 17) + 2);
        start = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            cyc = c;
            expect_out(c >= 5, 0, 1, 0, 0, 4'hF, 17'h0, 6'h0, 0);
            if (c == 8) rst = 1'b1;
            tick();
        end
        cyc = 9;
        expect_out(0, 0, 0, 0, 0, 4'hF, 17'h0, 6'h0, 1);
        rst = 1'b0;
        tick();
        for (int c = 1; c <= 5; c++) begin
            cyc = 100 + c;
            expect_out(c >= 5, 0, 1, 0, 0, 4'hF, 17'h0, 6'h0, 0);
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
